// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO consumer: pops one 32-bit word, waits out the read latency, streams it as bytes.
// Optional 5-byte framing with a leading SYNC_BYTE when FIFO_DRAIN_FRAME_HDR_EN is defined.
module fifo_drain_ctrl #(
  parameter int unsigned RD_LATENCY = 2,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        Rclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  input  logic        fifo_rd_err,
  output logic        ReadEN,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] words_sent,
  output logic [7:0]  rd_err_cnt
);

`ifdef FIFO_DRAIN_FRAME_HDR_EN
  localparam int unsigned NHDR = 1;
`else
  localparam int unsigned NHDR = 0;
`endif
  localparam logic [2:0] LAST = 3'(3 + NHDR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [2:0]  idx;
  logic [31:0] shreg;

  // Byte i of the outgoing frame; header (if any) occupies slot 0.
  function automatic logic [7:0] pick(
    input logic [31:0] w,
    input logic [2:0]  i
  );
    logic [31:0] v;
    logic [1:0]  k;
    v = MSB_FIRST ? w : {w[7:0], w[15:8], w[23:16], w[31:24]};
    k = 2'(i - 3'(NHDR));
    if (NHDR != 0 && i == 3'd0) return SYNC_BYTE;
    case (k)
      2'd0:    return v[31:24];
      2'd1:    return v[23:16];
      2'd2:    return v[15:8];
      default: return v[7:0];
    endcase
  endfunction

  always_ff @(posedge Rclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      ReadEN     <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      rd_err_cnt <= '0;
    end else begin
      ReadEN <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state  <= ISSUE;
            ReadEN <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= 2'(RD_LATENCY);
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (fifo_rd_err) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rd_err_cnt != 8'hFF)
              rd_err_cnt <= rd_err_cnt + 8'd1;
          end else if (cnt == 2'd1) begin
            shreg    <= fifo_data;
            idx      <= '0;
            tx_data  <= pick(fifo_data, 3'd0);
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST) begin
              tx_valid   <= 1'b0;
              words_sent <= words_sent + 16'd1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= pick(shreg, idx + 3'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
